// File: rtl/osc_tick_gen.sv
// osc_tick_gen: per-channel programmable tick divider with one-shot/periodic modes.
// Optional OSC_TICK_SYNC_EN adds sync_in for phase-aligning all running channels.
module osc_tick_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETN,
`ifdef OSC_TICK_SYNC_EN
  input  logic                    sync_in,
`endif
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_oneshot,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*8-1:0]     tick_cnt
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  logic sync;
`ifdef OSC_TICK_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0] state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, d, d_n, p, p_n, dv;
    logic [7:0] tcnt;
    logic en_q, mode, mode_n, rise, wrap, tick_q, tick_n;
    assign dv   = div_val[i*CNT_W +: CNT_W];
    assign rise = ch_en[i] & ~en_q;
    assign wrap = (state == RUN) && (cnt == d);
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mode_n  = mode;
      tick_n  = 1'b0;
      d_n     = wrap ? p : d;
      p_n     = div_load[i] ? dv : p;
      if (div_load[i] && state != RUN) d_n = dv;
      if (!ch_en[i]) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (state == IDLE && rise) begin
        state_n = RUN;
        cnt_n   = '0;
        mode_n  = ch_oneshot[i];
      end else if (state == RUN) begin
        cnt_n   = (wrap || sync) ? '0 : cnt + CNT_W'(1);
        tick_n  = wrap & ~sync;
        state_n = (tick_n && mode) ? DONE : RUN;
      end
    end
    always_ff @(posedge PCLK or negedge PRESETN)
      if (!PRESETN) begin
        state  <= IDLE;
        cnt    <= '0;
        d      <= '0;
        p      <= '0;
        mode   <= 1'b0;
        en_q   <= 1'b0;
        tick_q <= 1'b0;
        tcnt   <= '0;
      end else begin
        state  <= state_n;
        cnt    <= cnt_n;
        d      <= d_n;
        p      <= p_n;
        mode   <= mode_n;
        en_q   <= ch_en[i];
        tick_q <= tick_n;
        tcnt   <= tcnt + 8'(tick_n);
      end
    assign tick[i]          = tick_q;
    assign busy[i]          = state[0];
    assign tick_cnt[i*8 +: 8] = tcnt;
  end
endmodule

// File: tb/tb_osc_tick_gen.sv
// tb_osc_tick_gen: directed self-checking bench for osc_tick_gen (4 channels, 16-bit dividers).
module tb_osc_tick_gen;
  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic [3:0]  ch_en, ch_oneshot, div_load, tick, busy;
  logic [63:0] div_val;
  logic [31:0] tick_cnt;
  int          n_tests = 0, n_fail = 0;
`ifdef OSC_TICK_SYNC_EN
  logic        sync_in = 1'b0;
`endif

  osc_tick_gen #(.NUM_CH(4), .CNT_W(16)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
`ifdef OSC_TICK_SYNC_EN
    .sync_in(sync_in),
`endif
    .ch_en(ch_en), .ch_oneshot(ch_oneshot), .div_val(div_val), .div_load(div_load),
    .tick(tick), .busy(busy), .tick_cnt(tick_cnt)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic load(input int ch, input logic [15:0] v);
    div_val[ch*16 +: 16] = v;
    div_load[ch] = 1'b1;
    step();
    div_load[ch] = 1'b0;
  endtask

  initial begin
    PRESETN = 1'b0; ch_en = '0; ch_oneshot = '0; div_load = '0; div_val = '0;
    step(); step();
    check("rst tick", 32'(tick), 0);
    check("rst busy", 32'(busy), 0);
    check("rst tick_cnt", tick_cnt, 0);
    PRESETN = 1'b1;
    step();

    // ch0 periodic D=4: busy the cycle after enable, tick every 5 cycles
    load(0, 16'd4);
    ch_en[0] = 1'b1;
    step();
    check("ch0 busy on", 32'(busy[0]), 1);
    check("ch0 no early tick", 32'(tick[0]), 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("ch0 d4 tick k=%0d", k), 32'(tick[0]), 32'(k % 5 == 0));
    end
    check("ch0 tick_cnt 3", 32'(tick_cnt[7:0]), 3);

    // ch0 D=9, reload 2 mid-period, then disable with a tick due
    ch_en[0] = 1'b0;
    step();
    check("ch0 busy off", 32'(busy[0]), 0);
    load(0, 16'd9);
    ch_en[0] = 1'b1;
    step();
    for (int k = 1; k <= 29; k++) begin
      step();
      check($sformatf("ch0 reload tick k=%0d", k), 32'(tick[0]),
            32'(k == 10 || k == 20 || k == 23 || k == 26));
      if (k == 13) begin div_val[15:0] = 16'd2; div_load[0] = 1'b1; end
      if (k == 14) div_load[0] = 1'b0;
      if (k == 28) ch_en[0] = 1'b0;
    end
    check("ch0 busy after disable", 32'(busy[0]), 0);
    check("ch0 tick_cnt 7", 32'(tick_cnt[7:0]), 7);

    // ch2 one-shot D=3
    ch_oneshot[2] = 1'b1;
    load(2, 16'd3);
    ch_en[2] = 1'b1;
    step();
    check("ch2 busy on", 32'(busy[2]), 1);
    for (int k = 1; k <= 54; k++) begin
      step();
      check($sformatf("ch2 oneshot tick k=%0d", k), 32'(tick[2]), 32'(k == 4));
      if (k == 3) check("ch2 busy before tick", 32'(busy[2]), 1);
      if (k == 4 || k == 54) check($sformatf("ch2 busy done k=%0d", k), 32'(busy[2]), 0);
    end
    check("ch2 tick_cnt 1", 32'(tick_cnt[23:16]), 1);
    ch_en[2] = 1'b0;
    step();
    ch_en[2] = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("ch2 retrigger tick k=%0d", k), 32'(tick[2]), 32'(k == 4));
    end
    check("ch2 tick_cnt 2", 32'(tick_cnt[23:16]), 2);
    ch_en[2] = 1'b0;
    ch_oneshot[2] = 1'b0;

    // ch1 D=0 ticks every cycle, tick_cnt wraps after 256
    ch_en[1] = 1'b1;
    step();
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k == 1 || k == 100 || k == 256) check($sformatf("ch1 d0 tick k=%0d", k), 32'(tick[1]), 1);
      if (k == 255) check("ch1 tick_cnt 255", 32'(tick_cnt[15:8]), 255);
      if (k == 256) check("ch1 tick_cnt wrap", 32'(tick_cnt[15:8]), 0);
    end
    check("ch0 idle during ch1", 32'(tick[0]), 0);
    ch_en = '0;
    step();

    // reset mid-count on all channels at D=7
    div_val = {4{16'd7}};
    div_load = 4'hF;
    step();
    div_load = '0;
    ch_en = 4'hF;
    step(); step(); step(); step();
    check("all busy pre-reset", 32'(busy), 32'hF);
    #2 PRESETN = 1'b0;
    #1;
    check("async rst tick", 32'(tick), 0);
    check("async rst busy", 32'(busy), 0);
    check("async rst tick_cnt", tick_cnt, 0);
    div_load = 4'hF;
    step();
    PRESETN = 1'b1;
    step();
    div_load = '0;
    check("post-rst no tick", 32'(tick), 0);
    check("post-rst busy", 32'(busy), 32'hF);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("post-rst tick k=%0d", k), 32'(tick), (k == 8) ? 32'hF : 32'h0);
    end

`ifdef OSC_TICK_SYNC_EN
    ch_en = '0;
    step();
    div_val[15:0] = 16'd5;
    div_val[31:16] = 16'd7;
    div_load = 4'h3;
    step();
    div_load = '0;
    ch_en[0] = 1'b1;
    step(); step();
    ch_en[1] = 1'b1;
    step(); step(); step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync no tick", 32'(tick[1:0]), 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("sync ch0 k=%0d", k), 32'(tick[0]), 32'(k == 6));
      check($sformatf("sync ch1 k=%0d", k), 32'(tick[1]), 32'(k == 8));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/osc_tick_gen.md
OSC_TICK_GEN -- requirements
Module: osc_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: divider counter width per channel, range 2..32.
REQ-003 PCLK  input  1  single clock, fabric oscillator output; all logic rising-edge.
REQ-004 PRESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 ch_en  input  NUM_CH  per-channel run enable, level.
REQ-006 ch_oneshot  input  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic; sampled at ch_en rising edge.
REQ-007 div_val  input  NUM_CH*CNT_W  per-channel divide value, channel i at bits [i*CNT_W +: CNT_W].
REQ-008 div_load  input  NUM_CH  per-channel one-cycle strobe; captures that channel's div_val slice.
REQ-009 tick  output  NUM_CH  per-channel one-cycle strobe, registered.
REQ-010 busy  output  NUM_CH  channel counting, registered.
REQ-011 tick_cnt  output  NUM_CH*8  per-channel wrapping 8-bit count of ticks issued, registered.

Function
REQ-012 Each channel shall hold an active divider D and a pending divider P, both CNT_W bits; tick period = D+1 PCLK cycles (D=0: tick every cycle).
REQ-013 div_load while the channel is idle shall write D and P directly; while busy it shall write P only, and D<=P at the cycle the counter wraps.
REQ-014 Channel states: IDLE, RUN, DONE.
REQ-015 IDLE->RUN on ch_en rising edge (0 in previous cycle, 1 now): counter<=0, mode latched, busy=1 from next cycle.
REQ-016 In RUN the counter shall increment each cycle; when counter==D, tick=1 in the following cycle and counter<=0.
REQ-017 First tick after enable shall appear D+2 cycles after the cycle ch_en is first sampled high.
REQ-018 Periodic mode: RUN persists until ch_en=0.
REQ-019 One-shot mode: after the first tick RUN->DONE, busy=0; DONE->IDLE only when ch_en=0; no retrigger while ch_en stays 1.
REQ-020 ch_en=0 in any state: next cycle state IDLE, counter 0, busy 0, no tick; a tick already due that cycle is suppressed.
REQ-021 div_load and wrap in the same cycle: the new value shall go into P and become D at the next wrap.
REQ-022 tick_cnt shall increment on every issued tick, wrapping 255->0; cleared only by reset.
REQ-023 Channels shall be fully independent; no cross-channel ordering or arbitration.

Reset
REQ-024 PRESETN low shall asynchronously force every channel to IDLE with counter=0, D=0, P=0, tick=0, busy=0, tick_cnt=0.
REQ-025 Reset deassertion is synchronised externally; the first active edge after release behaves as a normal cycle, and ch_en already high at release counts as a rising edge.
REQ-026 Reset mid-count shall discard the pending tick; no tick in the cycle after release.

Configuration
REQ-027 Macro OSC_TICK_SYNC_EN, when defined, shall add input port sync_in (1 bit): a high sample forces every RUN channel's counter to 0 in the next cycle (phase alignment), suppresses that cycle's tick, and leaves state, mode, D and P unchanged.
REQ-028 sync_in and a wrap in the same cycle: sync wins, no tick, but a pending P still transfers to D.
REQ-029 Without OSC_TICK_SYNC_EN, port sync_in shall not exist and counters shall only clear on wrap, disable or reset.

Verification
REQ-030 Ch0 div_load D=4, periodic, ch_en 0->1 at cycle 10 -> ticks at cycles 16, 21, 26; busy=1 from cycle 11.
REQ-031 Ch1 D=0 periodic -> tick=1 every cycle after first; tick_cnt wraps 255->0 after 256 ticks.
REQ-032 Ch2 D=3 one-shot, ch_en held 1 -> exactly one tick, busy drops to 0, no further ticks for 50 cycles; ch_en 0 then 1 -> one more tick.
REQ-033 Ch0 running D=9, div_load 2 mid-period -> current period stays 10 cycles, following periods 3 cycles.
REQ-034 PRESETN pulsed low mid-count on all channels with D=7 -> all outputs 0 immediately, tick_cnt=0, first tick D+2 cycles after release with ch_en held 1.
REQ-035 OSC_TICK_SYNC_EN: ch0 D=5, ch1 D=7 running out of phase, sync_in pulse -> both counters 0 next cycle; ch0 ticks 6 and ch1 ticks 8 cycles after that cycle.
